// File: rtl/bp_cache_pkg.sv
// Shared helpers for the branch-predictor caches: clog2 and tree-PLRU victim/touch on up to 8 ways.
// Pure functions, no state; callers supply the live tree depth.
package bp_cache_pkg;

    typedef logic [6:0] plru_t;
    typedef logic [2:0] way_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2 (upper half).
    function automatic way_t plru_victim(input plru_t bits, input int lvls);
        way_t       w;
        logic [2:0] node;
        w    = '0;
        node = '0;
        for (int l = 0; l < 3; l++) begin
            if (l < lvls) begin
                w    = {w[1:0], bits[node]};
                node = {node[1:0], 1'b0} + 3'd1 + {2'b00, bits[node]};
            end
        end
        return w;
    endfunction

    function automatic plru_t plru_touch(input plru_t bits, input way_t way, input int lvls);
        plru_t      b;
        logic [2:0] node;
        way_t       s;
        b    = bits;
        node = '0;
        s    = way << (3 - lvls);
        for (int l = 0; l < 3; l++) begin
            if (l < lvls) begin
                b[node] = ~s[2];
                node    = {node[1:0], 1'b0} + 3'd1 + {2'b00, s[2]};
                s       = {s[1:0], 1'b0};
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/bp_plru.sv
// Per-set tree-PLRU state with a victim read port and write/read touch ports.
// Victim is combinational; touches land at posedge; never stalls.
module bp_plru
    import bp_cache_pkg::*;
#(
    parameter int SETS = 64,
    parameter int WAYS = 2,
    parameter int IW   = clog2(SETS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] vidx_i,
    output way_t          victim_o,
    input  logic          wt_vld_i,
    input  logic [IW-1:0] wt_idx_i,
    input  way_t          wt_way_i,
    input  logic          rt_vld_i,
    input  logic [IW-1:0] rt_idx_i,
    input  way_t          rt_way_i
);
    localparam int LVLS = clog2(WAYS);

    plru_t plru_q [SETS];
    plru_t plru_d [SETS];

    assign victim_o = plru_victim(plru_q[vidx_i], LVLS);

    // A write touch to the same set takes priority over the read touch.
    always_comb begin
        plru_d = plru_q;
        if (rt_vld_i && !(wt_vld_i && (wt_idx_i == rt_idx_i))) begin
            plru_d[rt_idx_i] = plru_touch(plru_q[rt_idx_i], rt_way_i, LVLS);
        end
        if (wt_vld_i) begin
            plru_d[wt_idx_i] = plru_touch(plru_q[wt_idx_i], wt_way_i, LVLS);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else begin
            plru_q <= plru_d;
        end
    end

endmodule

// File: rtl/bp_cache_assoc.sv
// Set-associative predictor cache: two combinational lookup ports, one write port, invalidate, write-to-read bypass.
// Lookups zero latency, writes/invalidates visible next cycle; no backpressure, write port accepts every cycle.
module bp_cache_assoc
    import bp_cache_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int LINES  = 128,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AWIDTH-1:0] ra0,
    input  logic [AWIDTH-1:0] ra1,
    input  logic [AWIDTH-1:0] wa,
    input  logic [DWIDTH-1:0] din,
    input  logic              we,
    input  logic              inv,
    input  logic [AWIDTH-1:0] ia,
    output logic [DWIDTH-1:0] dout0,
    output logic [DWIDTH-1:0] dout1,
    output logic              hit0,
    output logic              hit1
);
    localparam int SETS = LINES / WAYS;
    localparam int IW   = clog2(SETS);
    localparam int TW   = AWIDTH - IW;

    typedef struct packed {
        logic hit;
        way_t way;
    } probe_t;

    logic              valid_q [SETS][WAYS];
    logic [TW-1:0]     tag_q   [SETS][WAYS];
    logic [DWIDTH-1:0] data_q  [SETS][WAYS];

    function automatic probe_t probe(input logic [AWIDTH-1:0] a);
        probe_t p;
        p = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[a[IW-1:0]][w] && (tag_q[a[IW-1:0]][w] == a[AWIDTH-1:IW])) begin
                p.hit = 1'b1;
                p.way = way_t'(w);
            end
        end
        return p;
    endfunction

    probe_t            p0, p1, pw, pi;
    logic [DWIDTH-1:0] arr0, arr1;
    logic              fi_vld;
    way_t              fi_way, victim, w_way;
    logic              byp0, byp1;

    always_comb begin
        p0     = probe(ra0);
        p1     = probe(ra1);
        pw     = probe(wa);
        pi     = probe(ia);
        arr0   = '0;
        arr1   = '0;
        fi_vld = 1'b0;
        fi_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_t'(w) == p0.way) arr0 = data_q[ra0[IW-1:0]][w];
            if (way_t'(w) == p1.way) arr1 = data_q[ra1[IW-1:0]][w];
        end
        // Descending scan so the lowest-index invalid way is the one kept.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[wa[IW-1:0]][w]) begin
                fi_vld = 1'b1;
                fi_way = way_t'(w);
            end
        end
        w_way = pw.hit ? pw.way : (fi_vld ? fi_way : victim);
    end

    assign byp0  = we && !reset && (wa == ra0);
    assign byp1  = we && !reset && (wa == ra1);
    assign hit0  = !reset && (byp0 || p0.hit);
    assign hit1  = !reset && (byp1 || p1.hit);
    assign dout0 = reset ? '0 : (byp0 ? din : (p0.hit ? arr0 : '0));
    assign dout1 = reset ? '0 : (byp1 ? din : (p1.hit ? arr1 : '0));

    bp_plru #(
        .SETS (SETS),
        .WAYS (WAYS),
        .IW   (IW)
    ) u_plru (
        .clk      (clk),
        .reset    (reset),
        .vidx_i   (wa[IW-1:0]),
        .victim_o (victim),
        .wt_vld_i (we && !reset),
        .wt_idx_i (wa[IW-1:0]),
        .wt_way_i (w_way),
        .rt_vld_i (p0.hit && !byp0 && !reset),
        .rt_idx_i (ra0[IW-1:0]),
        .rt_way_i (p0.way)
    );

    // Write is applied after invalidate so a same-address pair leaves the entry valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
            end
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                if (inv && pi.hit && (pi.way == way_t'(w))) valid_q[ia[IW-1:0]][w] <= 1'b0;
                if (we && (w_way == way_t'(w)))             valid_q[wa[IW-1:0]][w] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we && !reset) begin
            for (int w = 0; w < WAYS; w++) begin
                if (w_way == way_t'(w)) begin
                    tag_q[wa[IW-1:0]][w]  <= wa[AWIDTH-1:IW];
                    data_q[wa[IW-1:0]][w] <= din;
                end
            end
        end
    end

endmodule
